// File: rtl/if_branch_resolve_queue.sv
// In-order queue of predicted branches between IF and EX; trains the GShare predictor
// and redirects on mispredict. Optional perf counters: define BRQ_PERF_CNT_EN.
module if_branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred_take,
  input  logic [31:0]      alloc_alt_pc,
  input  logic             resolve_valid,
  input  logic             resolve_take,
  input  logic             flush_in,
  output logic             pc_jmp_feedback,
  output logic             pc_jmp_take,
  output logic [31:0]      pc_stash_base,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
  output logic             resolve_err
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_resolved,
  output logic [31:0]      perf_mispredict
`endif
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic             pred_mem [DEPTH];
  logic [31:0]      alt_mem  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fb_q, fb_take_q, redir_q, err_q;
  logic [31:0]      stash_q, redir_pc_q;

  logic             do_resolve, mispredict, do_alloc;

  assign alloc_ready     = (count_q != FullCnt);
  assign count           = count_q;
  assign pc_jmp_feedback = fb_q;
  assign pc_jmp_take     = fb_take_q;
  assign pc_stash_base   = stash_q;
  assign redirect_valid  = redir_q;
  assign redirect_pc     = redir_pc_q;
  assign resolve_err     = err_q;

  // Flush outranks everything; a mispredict makes any same-cycle alloc wrong-path.
  always_comb begin
    do_resolve = resolve_valid && (count_q != '0) && !flush_in;
    mispredict = do_resolve && (resolve_take != pred_mem[head_q]);
    do_alloc   = alloc_valid && alloc_ready && !flush_in && !mispredict;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in || mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_alloc)   tail_d = tail_q + 1'b1;
      if (do_resolve) head_d = head_q + 1'b1;
      case ({do_alloc, do_resolve})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fb_q       <= 1'b0;
      fb_take_q  <= 1'b0;
      stash_q    <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fb_q       <= do_resolve;
      fb_take_q  <= do_resolve ? resolve_take : 1'b0;
      stash_q    <= do_resolve ? pc_mem[head_q] : '0;
      redir_q    <= mispredict;
      redir_pc_q <= mispredict ? alt_mem[head_q] : '0;
      if (resolve_valid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Entry payload needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      pc_mem[tail_q]   <= alloc_pc;
      pred_mem[tail_q] <= alloc_pred_take;
      alt_mem[tail_q]  <= alloc_alt_pc;
    end
  end

`ifdef BRQ_PERF_CNT_EN
  logic [31:0] perf_res_q, perf_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_res_q <= '0;
      perf_mis_q <= '0;
    end else begin
      if (do_resolve) perf_res_q <= perf_res_q + 32'd1;
      if (mispredict) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_resolved   = perf_res_q;
  assign perf_mispredict = perf_mis_q;
`endif

endmodule
